dti_fifo: RTL and testbench
===========================

// Module: dti_fifo
// PURPOSE
//  Elastic FIFO stage on a DTI channel, placed directly downstream of a pipe/dreg chain.
//  Absorbs consumer back-pressure so the register pipeline keeps streaming.
//  First-word-fall-through: data appears on dout one cycle after it is accepted on din.
//  Exposes its occupancy for upstream rate control and debug.
// PARAMETERS
//  DIN    16  data width in bits, equal to the W_DATA of the din/dout dti instances
//  DEPTH  4   number of storage entries; power of two, >= 2
// PORTS
//  clk         input   1                  single clock; all state updates on posedge
//  rst         input   1                  reset, asynchronous, active-low
//  din         dti.consumer               input channel: din.data[DIN], din.valid, din.ready
//  dout        dti.producer               output channel: dout.data[DIN], dout.valid, dout.ready
//  count       output  $clog2(DEPTH+1)    number of entries currently stored
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//   - wr_ptr=0, rd_ptr=0, count=0, dout.valid=0, din.ready=1 once rst is released.
//   - Storage contents are not reset; dout.data is don't-care while dout.valid=0.
//   - Reset asserted mid-transfer discards all stored entries.
//   - No handshake is counted in the cycle rst is deasserted.
//  Pointers
//   - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
//   - empty = (wr_ptr == rd_ptr).
//   - full = index bits equal AND wrap bits differ.
//   - Each pointer increments modulo 2*DEPTH and wraps naturally.
//  Handshake
//   - push = din.valid & din.ready; pop = dout.valid & dout.ready.
//   - din.ready = !full. It is registered-state-only and never combinationally depends on dout.ready.
//   - dout.valid = !empty; dout.data = mem[rd_ptr index].
//   - dout.data and dout.valid stay stable until pop (DTI producer rule).
//   - The block tolerates din.valid toggling. It accepts data only on push.
//  Latency / throughput
//   - A push in cycle N is visible on dout in cycle N+1.
//   - There is no combinational din->dout bypass, even when empty.
//   - Sustained throughput is 1 transfer/cycle when dout.ready is held at 1.
//  Boundary conditions
//   - Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
//   - Full: din.ready=0, so no push occurs even if a pop happens in the same cycle.
//     din.ready returns to 1 the cycle after the pop.
//   - Empty: dout.valid=0; a pop cannot occur.
//   - Pointer wrap: FIFO order is preserved across wrap; full/empty are decided by the wrap bit.
//  Arithmetic
//   - count = wr_ptr - rd_ptr, computed modulo 2*DEPTH and zero-extended.
//   - count is never greater than DEPTH.
// STRUCTURE
//  - No shared package: widths derive only from DIN and DEPTH, computed locally with localparams.
//  - One natural sub-module, fifo_ptr: wrap-bit pointer register with enable and asynchronous
//    active-low reset, instantiated twice (write side and read side).
//  - Storage is a plain register array written on push; there is no reset on the array.
//  - Elaboration-time assertion: DEPTH is a power of two and >= 2.
// TESTING
//  1. Reset: hold rst=0 with din.valid=1 -> dout.valid=0, count=0.
//     After release, din.ready=1 and the first push appears on dout one cycle later.
//  2. Streaming: DEPTH=4, push 0x0001..0x0010 back-to-back with dout.ready=1
//     -> 16 pops in order, 1/cycle, count stays <=1.
//  3. Fill: dout.ready=0, push 0xA0..0xA3 -> count=4, din.ready=0, 5th word 0xA4 not accepted.
//     Then dout.ready=1 -> 0xA0..0xA4 out in order.
//  4. Full with simultaneous pop: full FIFO, din.valid=1, dout.ready=1 for one cycle
//     -> one pop, no push, count=3; push happens the next cycle.
//  5. Wrap: 3*DEPTH transfers with random valid/ready (seeded)
//     -> scoreboard matches; dout stable while valid & !ready; count == pushes - pops at all times.
//  6. Reset mid-operation: pull rst low with count=3
//     -> dout.valid drops asynchronously, count=0; the stale 3 words never appear after release.

Source files
------------

// File: rtl/dti.sv
// DTI channel: one data word qualified by valid, accepted by ready.
// A transfer happens on every clock edge where valid and ready are both high.
interface dti #(
    parameter int W_DATA = 16
);
    logic [W_DATA-1:0] data;
    logic              valid;
    logic              ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_fifo_ptr.sv
// Wrap-bit pointer register for the FIFO.
// The MSB toggles each time the index bits roll over, so two pointers with equal
// index bits can still be told apart (full vs empty).
module fifo_ptr #(
    parameter int PW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Advance by one when enabled; the natural PW-bit overflow gives the modulo 2*DEPTH wrap
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    // Pointer state, cleared immediately when reset is pulled low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dti_fifo.sv
// Elastic first-word-fall-through FIFO on a DTI channel.
// Sits behind a register pipeline and soaks up consumer back-pressure. Ready on the
// input side comes only from stored pointer state, so no combinational path runs
// from dout.ready back to din.ready, and there is no din->dout bypass.
module dti_fifo #(
    parameter int DIN   = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    dti.consumer                       din,
    dti.producer                       dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Reject any depth the wrap-bit scheme cannot represent
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
        $error("dti_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  occupancy;
    logic           fifoEmpty;
    logic           fifoFull;
    logic           push;
    logic           pop;
    logic [DIN-1:0] mem_q [DEPTH];

    // Full and empty both come from pointer registers only
    always_comb begin
        fifoEmpty = (wrPtr == rdPtr);
        fifoFull  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
        push      = din.valid && !fifoFull;
        pop       = !fifoEmpty && dout.ready;
        occupancy = wrPtr - rdPtr;
    end

    fifo_ptr #(.PW(PW)) uWrPtr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (push),
        .ptr_o  (wrPtr)
    );

    fifo_ptr #(.PW(PW)) uRdPtr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (pop),
        .ptr_o  (rdPtr)
    );

    // Storage is written only on an accepted word; contents are never cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr[AW-1:0]] <= din.data;
        end
    end

    assign din.ready  = !fifoFull;
    assign dout.valid = !fifoEmpty;
    assign dout.data  = mem_q[rdPtr[AW-1:0]];
    assign count      = CW'(occupancy);

endmodule

// File: tb/tb_dti_fifo.sv
// Directed self-checking bench for dti_fifo (DIN=16, DEPTH=4).
// Inputs change and outputs are sampled on the falling edge; the FIFO acts on the rising edge.
module tb_dti_fifo;

    logic       clk;
    logic       rst;
    logic [2:0] count;
    int         errors;
    int         checks;

    dti #(.W_DATA(16)) dinIf ();
    dti #(.W_DATA(16)) doutIf ();

    dti_fifo #(.DIN(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (dinIf),
        .dout  (doutIf),
        .count (count)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Reset holds the FIFO empty even with valid high; first word falls through one cycle later
    task automatic test_reset();
        rst           = 1'b0;
        dinIf.valid   = 1'b1;
        dinIf.data    = 16'h1234;
        doutIf.ready  = 1'b0;
        tick();
        tick();
        checks++;
        if (doutIf.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", doutIf.valid);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dinIf.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", dinIf.ready);
        end
        tick();
        dinIf.valid = 1'b0;
        checks++;
        if (doutIf.valid !== 1'b1 || doutIf.data !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL reset_first_word: got valid=%b data=%h expected valid=1 data=1234",
                     doutIf.valid, doutIf.data);
        end
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL reset_first_count: got %0d expected 1", count);
        end
        doutIf.ready = 1'b1;
        tick();
        doutIf.ready = 1'b0;
        checks++;
        if (doutIf.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_drain: got valid=%b count=%0d expected valid=0 count=0",
                     doutIf.valid, count);
        end
    endtask

    // Back-to-back words with the consumer always ready: one in, one out every cycle
    task automatic test_streaming();
        doutIf.ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            dinIf.valid = 1'b1;
            dinIf.data  = 16'(i);
            tick();
            checks++;
            if (doutIf.valid !== 1'b1 || doutIf.data !== 16'(i)) begin
                errors++;
                $display("[TB] FAIL stream_word%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, doutIf.valid, doutIf.data, 16'(i));
            end
            checks++;
            if (count !== 3'd1) begin
                errors++;
                $display("[TB] FAIL stream_count%0d: got %0d expected 1", i, count);
            end
        end
        dinIf.valid = 1'b0;
        tick();
        checks++;
        if (doutIf.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL stream_end: got valid=%b count=%0d expected valid=0 count=0",
                     doutIf.valid, count);
        end
        doutIf.ready = 1'b0;
    endtask

    // Fill to capacity, show the fifth word is refused, then drain all five in order
    task automatic test_fill();
        doutIf.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dinIf.valid = 1'b1;
            dinIf.data  = 16'h00A0 + 16'(i);
            tick();
        end
        checks++;
        if (count !== 3'd4 || dinIf.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full: got count=%0d ready=%b expected count=4 ready=0",
                     count, dinIf.ready);
        end
        dinIf.data = 16'h00A4;
        tick();
        checks++;
        if (count !== 3'd4 || doutIf.data !== 16'h00A0) begin
            errors++;
            $display("[TB] FAIL fill_reject: got count=%0d head=%h expected count=4 head=00a0",
                     count, doutIf.data);
        end
        doutIf.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                dinIf.valid = 1'b0;
            end
            checks++;
            if (doutIf.valid !== 1'b1 || doutIf.data !== 16'h00A0 + 16'(k)) begin
                errors++;
                $display("[TB] FAIL fill_drain%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, doutIf.valid, doutIf.data, 16'h00A0 + 16'(k));
            end
            tick();
        end
        checks++;
        if (doutIf.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL fill_empty: got valid=%b count=%0d expected valid=0 count=0",
                     doutIf.valid, count);
        end
        doutIf.ready = 1'b0;
    endtask

    // A pop while full frees a slot but the waiting word only enters on the next cycle
    task automatic test_full_pop();
        doutIf.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dinIf.valid = 1'b1;
            dinIf.data  = 16'h00B0 + 16'(i);
            tick();
        end
        dinIf.data   = 16'h00B4;
        doutIf.ready = 1'b1;
        tick();
        doutIf.ready = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("[TB] FAIL fullpop_count: got %0d expected 3", count);
        end
        checks++;
        if (dinIf.ready !== 1'b1 || doutIf.data !== 16'h00B1) begin
            errors++;
            $display("[TB] FAIL fullpop_state: got ready=%b head=%h expected ready=1 head=00b1",
                     dinIf.ready, doutIf.data);
        end
        tick();
        dinIf.valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL fullpop_late_push: got %0d expected 4", count);
        end
        doutIf.ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (doutIf.valid !== 1'b1 || doutIf.data !== 16'h00B0 + 16'(k)) begin
                errors++;
                $display("[TB] FAIL fullpop_drain%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, doutIf.valid, doutIf.data, 16'h00B0 + 16'(k));
            end
            tick();
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL fullpop_empty: got %0d expected 0", count);
        end
        doutIf.ready = 1'b0;
    endtask

    // Seeded random valid/ready over several pointer wraps against a queue model
    task automatic test_wrap();
        logic [15:0] model [$];
        logic [15:0] heldData;
        logic        heldStall;
        logic        doPush;
        logic        doPop;
        int          pushes;
        int          pops;
        int          cycles;
        pushes    = 0;
        pops      = 0;
        cycles    = 0;
        heldStall = 1'b0;
        heldData  = '0;
        void'($urandom(32'd20240611));
        while (pops < 12 && cycles < 500) begin
            checks++;
            if (count !== 3'(pushes - pops)) begin
                errors++;
                $display("[TB] FAIL wrap_count c%0d: got %0d expected %0d", cycles, count, pushes - pops);
            end
            checks++;
            if (doutIf.valid !== (model.size() > 0) || dinIf.ready !== (model.size() < 4)) begin
                errors++;
                $display("[TB] FAIL wrap_flags c%0d: got valid=%b ready=%b expected valid=%b ready=%b",
                         cycles, doutIf.valid, dinIf.ready, model.size() > 0, model.size() < 4);
            end
            if (model.size() > 0) begin
                checks++;
                if (doutIf.data !== model[0]) begin
                    errors++;
                    $display("[TB] FAIL wrap_data c%0d: got %h expected %h", cycles, doutIf.data, model[0]);
                end
            end
            if (heldStall) begin
                checks++;
                if (doutIf.data !== heldData) begin
                    errors++;
                    $display("[TB] FAIL wrap_stable c%0d: got %h expected %h", cycles, doutIf.data, heldData);
                end
            end
            dinIf.valid  = (pushes < 12) && ($urandom_range(0, 2) != 0);
            dinIf.data   = 16'($urandom);
            doutIf.ready = ($urandom_range(0, 2) != 0);
            doPush    = dinIf.valid && (model.size() < 4);
            doPop     = doutIf.ready && (model.size() > 0);
            heldStall = (model.size() > 0) && !doutIf.ready;
            heldData  = (model.size() > 0) ? model[0] : 16'h0000;
            if (doPop) begin
                void'(model.pop_front());
                pops++;
            end
            if (doPush) begin
                model.push_back(dinIf.data);
                pushes++;
            end
            tick();
            cycles++;
        end
        dinIf.valid  = 1'b0;
        doutIf.ready = 1'b0;
        checks++;
        if (pops < 12) begin
            errors++;
            $display("[TB] FAIL wrap_timeout: got %0d pops expected 12", pops);
        end
    endtask

    // Reset in the middle of a cycle empties the FIFO at once and old words never resurface
    task automatic test_reset_mid();
        doutIf.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dinIf.valid = 1'b1;
            dinIf.data  = 16'h00C0 + 16'(i);
            tick();
        end
        dinIf.valid = 1'b0;
        checks++;
        if (count !== 3'd3 || doutIf.valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got count=%0d valid=%b expected count=3 valid=1",
                     count, doutIf.valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (doutIf.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got valid=%b count=%0d expected valid=0 count=0",
                     doutIf.valid, count);
        end
        tick();
        rst          = 1'b1;
        doutIf.ready = 1'b1;
        tick();
        checks++;
        if (doutIf.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midrst_stale: got valid=%b count=%0d expected valid=0 count=0",
                     doutIf.valid, count);
        end
        dinIf.valid = 1'b1;
        dinIf.data  = 16'h00D0;
        tick();
        dinIf.valid = 1'b0;
        checks++;
        if (doutIf.valid !== 1'b1 || doutIf.data !== 16'h00D0 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL midrst_new: got valid=%b data=%h count=%0d expected valid=1 data=00d0 count=1",
                     doutIf.valid, doutIf.data, count);
        end
        tick();
        checks++;
        if (doutIf.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midrst_final: got valid=%b count=%0d expected valid=0 count=0",
                     doutIf.valid, count);
        end
        doutIf.ready = 1'b0;
    endtask

    // Run every scenario in order, then report
    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        dinIf.valid  = 1'b0;
        dinIf.data   = '0;
        doutIf.ready = 1'b0;
        tick();
        test_reset();
        test_streaming();
        test_fill();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
